// File: rtl/scan_display_mux_if.sv
// rtl/scan_display_mux_if.sv - digit bank, scan controls and display pins of the seven-segment scanner
interface scan_display_mux_if #(
  parameter int NUM_DIGITS = 6,
  parameter int NUM_POS    = 4,
  parameter int SEG_W      = 7,
  parameter int BRIGHT_W   = 4
) ();
  localparam int PAGES  = (NUM_DIGITS + NUM_POS - 1) / NUM_POS;
  localparam int PAGE_W = $clog2(PAGES) + 1;
  localparam int LEN_W  = $clog2(NUM_POS) + 1;
  localparam int POS_W  = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;

  logic [NUM_DIGITS*SEG_W-1:0] DIGITS_IN;
  logic [NUM_DIGITS-1:0]       DIGIT_EN_IN;
  logic [NUM_DIGITS-1:0]       BLINK_IN;
  logic [PAGE_W-1:0]           PAGE_SEL_IN;
  logic [LEN_W-1:0]            SCAN_LEN_IN;
  logic [BRIGHT_W-1:0]         BRIGHT_IN;
  logic [SEG_W-1:0]            SEG_OUT;
  logic [NUM_POS-1:0]          EN_OUT;
  logic [POS_W-1:0]            POS_OUT;
  logic                        FRAME_OUT;

  modport master (
    output DIGITS_IN, DIGIT_EN_IN, BLINK_IN, PAGE_SEL_IN, SCAN_LEN_IN, BRIGHT_IN,
    input  SEG_OUT, EN_OUT, POS_OUT, FRAME_OUT
  );

  modport slave (
    input  DIGITS_IN, DIGIT_EN_IN, BLINK_IN, PAGE_SEL_IN, SCAN_LEN_IN, BRIGHT_IN,
    output SEG_OUT, EN_OUT, POS_OUT, FRAME_OUT
  );
endinterface

// File: rtl/scan_display_mux.sv
// rtl/scan_display_mux.sv - time-multiplexed seven-segment scanner with dead time, PWM dimming and blink
module scan_display_mux #(
  parameter int NUM_DIGITS  = 6,
  parameter int NUM_POS     = 4,
  parameter int SEG_W       = 7,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 2,
  parameter int BRIGHT_W    = 4,
  parameter int BLINK_DIV   = 256
) (
  input logic CLK_IN,
  input logic RST_IN,
  scan_display_mux_if.slave bus
);
  localparam int PAGES   = (NUM_DIGITS + NUM_POS - 1) / NUM_POS;
  localparam int PAGE_W  = $clog2(PAGES) + 1;
  localparam int LEN_W   = $clog2(NUM_POS) + 1;
  localparam int POS_W   = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_DEAD  = SLOT_W'(DEAD_CYCLES);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

  logic [SLOT_W-1:0]   slot_cnt;
  logic [POS_W-1:0]    pos;
  logic [PAGE_W-1:0]   page_q;
  logic [LEN_W-1:0]    len_q;
  logic [SEG_W-1:0]    seg_q;
  logic                en_q;
  logic                blink_q;
  logic [BRIGHT_W-1:0] bright_cnt;
  logic [FRAME_W-1:0]  frame_cnt;
  logic                blink_phase;

  logic [SEG_W-1:0]    seg_out;
  logic [NUM_POS-1:0]  en_out;
  logic [POS_W-1:0]    pos_out;
  logic                frame_out;

  logic                slot_start;
  logic [LEN_W-1:0]    len_live;
  logic [PAGE_W-1:0]   page_cur;
  logic [POS_W-1:0]    pos_cur;
  int                  idx;
  logic [SEG_W-1:0]    seg_live, seg_cur;
  logic                en_live, en_cur;
  logic                blink_live, blink_cur;
  logic                pwm_on;
  logic                visible;
  logic                wrap;

  // On the first clock of a slot the live inputs are used directly, so the
  // digit shown never depends on whether the latch has been written yet.
  always_comb begin
    slot_start = (slot_cnt == '0);
    len_live   = bus.SCAN_LEN_IN;
    if (bus.SCAN_LEN_IN == '0)
      len_live = LEN_W'(1);
    else if (int'(bus.SCAN_LEN_IN) > NUM_POS)
      len_live = LEN_W'(NUM_POS);
    page_cur = slot_start ? bus.PAGE_SEL_IN : page_q;
    pos_cur  = pos;
    if (slot_start && int'(pos) >= int'(len_live))
      pos_cur = '0;
    idx        = int'(page_cur) * NUM_POS + int'(pos_cur);
    seg_live   = '1;
    en_live    = 1'b0;
    blink_live = 1'b0;
    // Indices past the bank never match, leaving the position disabled.
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx == d) begin
        seg_live   = bus.DIGITS_IN[d*SEG_W +: SEG_W];
        en_live    = bus.DIGIT_EN_IN[d];
        blink_live = bus.BLINK_IN[d];
      end
    end
    seg_cur   = slot_start ? seg_live   : seg_q;
    en_cur    = slot_start ? en_live    : en_q;
    blink_cur = slot_start ? blink_live : blink_q;
    pwm_on    = (&bus.BRIGHT_IN) || (bright_cnt < bus.BRIGHT_IN);
    visible   = en_cur && !(blink_cur && blink_phase) && (slot_cnt >= SLOT_DEAD) && pwm_on;
    wrap      = (slot_cnt == SLOT_LAST) && (int'(pos) + 1 >= int'(len_q));
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      slot_cnt    <= '0;
      pos         <= '0;
      page_q      <= '0;
      len_q       <= LEN_W'(1);
      seg_q       <= '1;
      en_q        <= 1'b0;
      blink_q     <= 1'b0;
      bright_cnt  <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_out     <= '1;
      en_out      <= '1;
      pos_out     <= '0;
      frame_out   <= 1'b0;
    end else begin
      bright_cnt <= bright_cnt + 1'b1;
      if (slot_start) begin
        page_q  <= bus.PAGE_SEL_IN;
        len_q   <= len_live;
        seg_q   <= seg_live;
        en_q    <= en_live;
        blink_q <= blink_live;
        pos     <= pos_cur;
      end
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        pos      <= wrap ? '0 : pos + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (wrap) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      seg_out   <= visible ? seg_cur : '1;
      en_out    <= visible ? ~(NUM_POS'(1) << pos_cur) : '1;
      pos_out   <= pos_cur;
      frame_out <= slot_start && (pos_cur == '0);
    end
  end

  assign bus.SEG_OUT   = seg_out;
  assign bus.EN_OUT    = en_out;
  assign bus.POS_OUT   = pos_out;
  assign bus.FRAME_OUT = frame_out;
endmodule

// File: tb/tb_scan_display_mux.sv
// tb/tb_scan_display_mux.sv - scoreboard bench for scan_display_mux with directed per-slot vectors
module tb_scan_display_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_display_mux_if #(.NUM_DIGITS(6), .NUM_POS(4), .SEG_W(7), .BRIGHT_W(2)) bus ();

  scan_display_mux #(
    .NUM_DIGITS(6), .NUM_POS(4), .SEG_W(7), .SCAN_DIV(8),
    .DEAD_CYCLES(2), .BRIGHT_W(2), .BLINK_DIV(2)
  ) dut (
    .CLK_IN(clk),
    .RST_IN(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] en;
    logic [6:0] seg;
    logic [1:0] pos;
    logic       frm;
  } exp_t;

  exp_t exp_q[$];
  logic [6:0] dig [0:5];
  int checks = 0;
  int errors = 0;
  localparam logic [7:0] FULL = 8'hFC;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int t = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.EN_OUT !== e.en || bus.SEG_OUT !== e.seg || bus.POS_OUT !== e.pos || bus.FRAME_OUT !== e.frm) begin
          errors++;
          $display("FAIL scan t=%0d: got en=%b seg=%h pos=%0d frame=%b, expected en=%b seg=%h pos=%0d frame=%b",
                   t, bus.EN_OUT, bus.SEG_OUT, bus.POS_OUT, bus.FRAME_OUT, e.en, e.seg, e.pos, e.frm);
        end
        t++;
      end
    end
  endtask

  // mask bit k marks the slot clocks where the position should be lit
  task automatic push_slot(input int p, input bit lit, input int d, input bit frm,
                           input logic [7:0] mask, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.en  = (lit && mask[k]) ? ~(4'b0001 << p) : 4'hF;
      e.seg = (lit && mask[k]) ? dig[d] : 7'h7F;
      e.pos = 2'(p);
      e.frm = frm && (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int mid_len);
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (mid_len >= 0 && exp_q.size() == 4)
        bus.SCAN_LEN_IN = 3'(mid_len);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_slot(input int p, input bit lit, input int d, input bit frm, input logic [7:0] mask);
    push_slot(p, lit, d, frm, mask, 8);
    drain(-1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none
    dig[0] = 7'h40; dig[1] = 7'h79; dig[2] = 7'h24;
    dig[3] = 7'h30; dig[4] = 7'h19; dig[5] = 7'h12;
    for (int d = 0; d < 6; d++) bus.DIGITS_IN[d*7 +: 7] = dig[d];
    bus.DIGIT_EN_IN = 6'h3F;
    bus.BLINK_IN    = 6'h00;
    bus.PAGE_SEL_IN = 2'd0;
    bus.SCAN_LEN_IN = 3'd4;
    bus.BRIGHT_IN   = 2'd3;

    repeat (3) @(posedge clk);
    #1;
    check("reset en", 16'(bus.EN_OUT), 16'hF);
    check("reset seg", 16'(bus.SEG_OUT), 16'h7F);
    check("reset pos", 16'(bus.POS_OUT), 16'h0);
    check("reset frame", 16'(bus.FRAME_OUT), 16'h0);

    @(negedge clk);
    #1;
    push_slot(0, 1, 0, 1, FULL, 8);
    rst = 1'b0;
    drain(-1);
    do_slot(1, 1, 1, 0, FULL);
    do_slot(2, 1, 2, 0, FULL);
    do_slot(3, 1, 3, 0, FULL);
    do_slot(0, 1, 0, 1, FULL);

    bus.PAGE_SEL_IN = 2'd1;
    bus.SCAN_LEN_IN = 3'd2;
    do_slot(1, 1, 5, 0, FULL);
    do_slot(0, 1, 4, 1, FULL);
    do_slot(1, 1, 5, 0, FULL);
    do_slot(0, 1, 4, 1, FULL);
    bus.SCAN_LEN_IN = 3'd4;
    do_slot(1, 1, 5, 0, FULL);
    do_slot(2, 0, 0, 0, FULL);
    do_slot(3, 0, 0, 0, FULL);
    do_slot(0, 1, 4, 1, FULL);

    bus.PAGE_SEL_IN = 2'd0;
    do_slot(1, 1, 1, 0, FULL);
    push_slot(2, 1, 2, 0, FULL, 8);
    drain(1);
    do_slot(0, 1, 0, 1, FULL);
    do_slot(0, 1, 0, 1, FULL);
    bus.SCAN_LEN_IN = 3'd0;
    do_slot(0, 1, 0, 1, FULL);
    do_slot(0, 1, 0, 1, FULL);

    bus.SCAN_LEN_IN = 3'd4;
    bus.BRIGHT_IN   = 2'd1;
    do_slot(0, 1, 0, 1, 8'h10);
    do_slot(1, 1, 1, 0, 8'h10);
    bus.BRIGHT_IN = 2'd0;
    do_slot(2, 1, 2, 0, 8'h00);
    do_slot(3, 1, 3, 0, 8'h00);

    bus.BRIGHT_IN = 2'd3;
    do_slot(0, 1, 0, 1, FULL);
    push_slot(1, 1, 1, 0, FULL, 4);
    drain(-1);
    check("pre-reset en", 16'(bus.EN_OUT), 16'hD);
    rst = 1'b1;
    #1;
    check("async reset en", 16'(bus.EN_OUT), 16'hF);
    check("async reset seg", 16'(bus.SEG_OUT), 16'h7F);
    check("async reset pos", 16'(bus.POS_OUT), 16'h0);
    check("async reset frame", 16'(bus.FRAME_OUT), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("held reset en", 16'(bus.EN_OUT), 16'hF);

    bus.BLINK_IN = 6'b000010;
    @(negedge clk);
    #1;
    push_slot(0, 1, 0, 1, FULL, 8);
    rst = 1'b0;
    drain(-1);
    for (int f = 0; f < 5; f++) begin
      for (int p = 0; p < 4; p++) begin
        if (f != 0 || p != 0)
          do_slot(p, !(p == 1 && (f == 2 || f == 3)), p, p == 0, FULL);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_display_mux.md
# scan_display_mux

Parametrised time-multiplexed seven-segment driver for the watch display path. It scans up to NUM_POS physical common-anode positions from a bank of NUM_DIGITS encoded digits. A page selector generalises the seconds/hours-minutes switch, and a programmable scan length picks how many positions are lit. On top of plain scanning it adds anti-ghosting dead time, PWM brightness, and per-digit blinking for time-set editing. It sits between the per-digit segment encoders and the board pins.

## Interface
- NUM_DIGITS, 6: digits in the input bank.
- NUM_POS, 4: physical display positions (enable pins).
- SEG_W, 7: segment lines per digit (bit0=A … bit6=G; 8 adds DP).
- SCAN_DIV, 1000: clocks per position slot; must be > DEAD_CYCLES+1.
- DEAD_CYCLES, 2: blank clocks at the start of each slot.
- BRIGHT_W, 4: brightness resolution.
- BLINK_DIV, 256: full frames per blink half-period.
- CLK_IN  in  1  system clock, all logic on rising edge.
- RST_IN  in  1  reset, asynchronous, active-high.
- DIGITS_IN  in  NUM_DIGITS*SEG_W  digit d segments at [d*SEG_W +: SEG_W], active-low.
- DIGIT_EN_IN  in  NUM_DIGITS  1 = digit may be lit.
- BLINK_IN  in  NUM_DIGITS  1 = digit blinks.
- PAGE_SEL_IN  in  $clog2(ceil(NUM_DIGITS/NUM_POS))+1  page index.
- SCAN_LEN_IN  in  $clog2(NUM_POS)+1  positions scanned (1..NUM_POS).
- BRIGHT_IN  in  BRIGHT_W  duty; all-ones = always on.
- SEG_OUT  out  SEG_W  segment lines, active-low, registered.
- EN_OUT  out  NUM_POS  position enables, active-low, at most one low, registered.
- POS_OUT  out  $clog2(NUM_POS)  position of the current slot, registered.
- FRAME_OUT  out  1  one-clock pulse on the first clock of position 0's slot.

## Operation
- Reset value of every output: SEG_OUT all ones, EN_OUT all ones, POS_OUT 0, FRAME_OUT 0.
- Reset value of internal state: slot_cnt 0, pos 0, bright_cnt 0, frame_cnt 0, blink_phase 0 (visible).
- slot_cnt counts 0..SCAN_DIV-1. At wrap, pos advances.
- pos wraps to 0 when pos+1 ≥ eff_len.
  - eff_len = SCAN_LEN_IN clamped to 1..NUM_POS (0 counts as 1).
- Slot-start latch at slot_cnt==0: capture page, eff_len, the selected digit's segments, enable, and blink.
  - Latched values hold for the whole slot; inputs changing mid-slot have no effect until the next slot.
- If the latched eff_len ≤ pos, pos restarts at 0 at that boundary.
- Digit index = page*NUM_POS + pos. If index ≥ NUM_DIGITS, the position is treated as disabled.
- A digit is visible when all of these hold:
  - DIGIT_EN latched 1;
  - not (BLINK latched 1 and blink_phase 1);
  - slot_cnt ≥ DEAD_CYCLES;
  - PWM on, i.e. BRIGHT_IN all ones, or bright_cnt < BRIGHT_IN.
- bright_cnt is a free-running BRIGHT_W-bit counter that wraps naturally.
- When visible: EN_OUT[pos] = 0, other enables 1, SEG_OUT = latched segments.
- When not visible: EN_OUT all ones and SEG_OUT all ones. SEG_OUT and EN_OUT never change together with a stale digit.
- frame_cnt counts completed frames (pos wraps to 0). At BLINK_DIV-1 it clears and blink_phase toggles.
- BRIGHT_IN = 0 with BRIGHT_W bits gives permanently dark. All-ones gives 100 %.

## Timing
- All outputs are registered. The value for internal state at edge n appears after edge n+1 (1-clock latency).
- Slot length is exactly SCAN_DIV clocks. Frame length is eff_len*SCAN_DIV clocks.
- Dead time: the first DEAD_CYCLES output clocks of every slot have EN_OUT all ones, including slots of disabled digits.
- POS_OUT changes on the same edge as the first dead clock of the new slot.
- FRAME_OUT is high for exactly that one edge when pos is 0.
- SCAN_LEN_IN or PAGE_SEL_IN changes take effect at the next slot boundary only, never mid-slot.
- RST_IN asserted mid-slot: outputs go to reset values immediately (asynchronously).
- First slot after reset release begins at the first rising edge with RST_IN low; slot_cnt starts at 0 there.

## Test plan
Bench parameters: NUM_DIGITS=6, NUM_POS=4, SCAN_DIV=8, DEAD_CYCLES=2, BRIGHT_W=2, BLINK_DIV=2.
- Page 0, SCAN_LEN_IN=4, BRIGHT_IN=3, all digits enabled and distinct -> EN_OUT sequence per slot: 2 clocks 4'b1111, then 6 clocks 1110/1101/1011/0111. SEG_OUT matches digits 0..3. FRAME_OUT pulses every 32 clocks.
- Page 1, SCAN_LEN_IN=2 -> digits 4, 5 on positions 0, 1. Positions 2, 3 never low. Frame 16 clocks. Set SCAN_LEN_IN=4 -> positions 2, 3 stay dark (index ≥ 6).
- SCAN_LEN_IN changed 4→1 while pos=2 -> current slot completes unchanged. Next slot is pos 0 and only EN_OUT[0] pulses thereafter. SCAN_LEN_IN=0 behaves as 1.
- BRIGHT_IN=1 -> in the non-dead part of a slot, EN_OUT[pos] low only when bright_cnt==0 (25 % duty). BRIGHT_IN=0 -> EN_OUT stays 4'b1111.
- BLINK_IN[1]=1 -> digit 1 dark for 2 frames, lit for 2 frames, alternating. Other digits are unaffected.
- Assert RST_IN mid-slot with EN_OUT=1101 -> EN_OUT=1111, SEG_OUT=all ones, POS_OUT=0 without a clock edge. After release, scanning restarts at pos 0 with dead time.
